// File: rtl/register_file_pkg.sv
// Shared RV32I definitions: register-file geometry, ABI register names and
// the read-port forwarding predicate.
package rv32i_defs;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_COUNT  = 32;
    localparam int unsigned XLEN       = 32;

    typedef enum logic [REG_ADDR_W-1:0] {
        ZERO = 5'd0,  RA  = 5'd1,  SP  = 5'd2,  GP  = 5'd3,
        TP   = 5'd4,  T0  = 5'd5,  T1  = 5'd6,  T2  = 5'd7,
        S0   = 5'd8,  S1  = 5'd9,  A0  = 5'd10, A1  = 5'd11,
        A2   = 5'd12, A3  = 5'd13, A4  = 5'd14, A5  = 5'd15,
        A6   = 5'd16, A7  = 5'd17, S2  = 5'd18, S3  = 5'd19,
        S4   = 5'd20, S5  = 5'd21, S6  = 5'd22, S7  = 5'd23,
        S8   = 5'd24, S9  = 5'd25, S10 = 5'd26, S11 = 5'd27,
        T3   = 5'd28, T4  = 5'd29, T5  = 5'd30, T6  = 5'd31
    } abi_reg_e;

    // A pending write targets this read port; x0 is never forwarded.
    function automatic logic fwd_hit(input logic                  wr_ena,
                                     input logic [REG_ADDR_W-1:0] wr_addr,
                                     input logic [REG_ADDR_W-1:0] rd_addr);
        return wr_ena && (wr_addr == rd_addr) && (rd_addr != REG_ADDR_W'(0));
    endfunction

endpackage

// File: rtl/register_file_if.sv
// Write-port / dual-read-port bundle between writeback, operand fetch and the register file.
interface register_file_if
    import rv32i_defs::*;
#(
    parameter int unsigned N = 32
);
    logic                  wr_ena;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [N-1:0]          wr_data;
    logic [REG_ADDR_W-1:0] rd_addr0;
    logic [N-1:0]          rd_data0;
    logic [REG_ADDR_W-1:0] rd_addr1;
    logic [N-1:0]          rd_data1;

    modport master (
        output wr_ena, wr_addr, wr_data, rd_addr0, rd_addr1,
        input  rd_data0, rd_data1
    );

    modport slave (
        input  wr_ena, wr_addr, wr_data, rd_addr0, rd_addr1,
        output rd_data0, rd_data1
    );
endinterface

// File: rtl/register_file_decoder.sv
// One-hot write-enable decode of a 5-bit register index, gated by the write enable.
module decoder_5_to_32
    import rv32i_defs::*;
(
    input  logic                  ena,
    input  logic [REG_ADDR_W-1:0] addr,
    output logic [REG_COUNT-1:0]  onehot
);
    always_comb begin
        onehot = '0;
        if (ena) begin
            onehot[addr] = 1'b1;
        end
    end
endmodule

// File: rtl/register_file_mux.sv
// Generic 32:1 read-select multiplexer, W bits wide.
module mux_32_to_1
    import rv32i_defs::*;
#(
    parameter int unsigned W = 32
)(
    input  logic [W-1:0]          din [REG_COUNT],
    input  logic [REG_ADDR_W-1:0] sel,
    output logic [W-1:0]          dout
);
    assign dout = din[sel];
endmodule

// File: rtl/register_file.sv
// 31 x N-bit register file with hardwired-zero x0, one synchronous write port,
// two combinational read ports and optional same-cycle write forwarding.
module register_file
    import rv32i_defs::*;
#(
    parameter int unsigned N      = 32,
    parameter bit          BYPASS = 1'b1
)(
    input  logic             clk,
    input  logic             rst_n,
    register_file_if.slave   bus
);
    logic [REG_COUNT-1:0] wr_sel;
    logic [N-1:0]         regs [REG_COUNT];
    logic [N-1:0]         mux_out0;
    logic [N-1:0]         mux_out1;
    logic                 unused_sel0;

    decoder_5_to_32 u_dec (
        .ena    (bus.wr_ena),
        .addr   (bus.wr_addr),
        .onehot (wr_sel)
    );

    // x0 has no storage, so its decoded enable is simply dropped.
    assign unused_sel0 = wr_sel[0];
    assign regs[0]     = '0;

    for (genvar i = 1; i < REG_COUNT; i++) begin : g_reg
        logic [N-1:0] q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
            end else if (wr_sel[i]) begin
                q <= bus.wr_data;
            end
        end

        assign regs[i] = q;
    end

    mux_32_to_1 #(.W(N)) u_mux0 (
        .din  (regs),
        .sel  (bus.rd_addr0),
        .dout (mux_out0)
    );

    mux_32_to_1 #(.W(N)) u_mux1 (
        .din  (regs),
        .sel  (bus.rd_addr1),
        .dout (mux_out1)
    );

    // Forwarding is suppressed in reset; stored contents are already zero then.
    always_comb begin
        bus.rd_data0 = mux_out0;
        bus.rd_data1 = mux_out1;
        if (BYPASS && rst_n) begin
            if (fwd_hit(bus.wr_ena, bus.wr_addr, bus.rd_addr0)) begin
                bus.rd_data0 = bus.wr_data;
            end
            if (fwd_hit(bus.wr_ena, bus.wr_addr, bus.rd_addr1)) begin
                bus.rd_data1 = bus.wr_data;
            end
        end
    end
endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: one BYPASS=1 and one BYPASS=0 instance share stimulus.
module tb_register_file;
    import rv32i_defs::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    register_file_if #(.N(32)) ifb ();
    register_file_if #(.N(32)) ifn ();

    register_file #(.N(32), .BYPASS(1'b1)) dut_byp (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    register_file #(.N(32), .BYPASS(1'b0)) dut_nob (.clk(clk), .rst_n(rst_n), .bus(ifn.slave));

    int errors  = 0;
    int checks  = 0;
    int req_cnt = 0;
    string        name_q [$];
    logic [127:0] exp_q  [$];

    task automatic drive(input logic ena, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        ifb.wr_ena = ena; ifb.wr_addr = wa; ifb.wr_data = wd; ifb.rd_addr0 = ra0; ifb.rd_addr1 = ra1;
        ifn.wr_ena = ena; ifn.wr_addr = wa; ifn.wr_data = wd; ifn.rd_addr0 = ra0; ifn.rd_addr1 = ra1;
    endtask

    // Expected: bypass-instance port0/port1, then no-bypass-instance port0/port1.
    task automatic chk(input string nm, input logic [31:0] b0, input logic [31:0] b1,
                       input logic [31:0] n0, input logic [31:0] n1);
        name_q.push_back(nm);
        exp_q.push_back({b0, b1, n0, n1});
        req_cnt++;
        #2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sweep_val(input int a);
        return (a == 0) ? 32'h0 : 32'h0000_1000 + 32'(a);
    endfunction

    function automatic void cmp(input string nm, input string port,
                                input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %h expected %h", nm, port, act, exp);
        end
    endfunction

    // Monitor: pops one expectation per request and samples all four read ports.
    initial begin
        string        nm;
        logic [127:0] e;
        forever begin
            @(req_cnt);
            #1;
            if (name_q.size() > 0) begin
                nm = name_q.pop_front();
                e  = exp_q.pop_front();
                cmp(nm, "byp.rd0", ifb.rd_data0, e[127:96]);
                cmp(nm, "byp.rd1", ifb.rd_data1, e[95:64]);
                cmp(nm, "nob.rd0", ifn.rd_data0, e[63:32]);
                cmp(nm, "nob.rd1", ifn.rd_data1, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic sweep(input string nm, input logic all_zero);
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            tick();
            if (all_zero)
                chk(nm, 32'h0, 32'h0, 32'h0, 32'h0);
            else
                chk(nm, sweep_val(i), sweep_val(31 - i), sweep_val(i), sweep_val(31 - i));
        end
    endtask

    initial begin
        drive(1'b0, ZERO, 32'h0, T0, T6);
        #2;
        chk("reset_init", 32'h0, 32'h0, 32'h0, 32'h0);
        rst_n = 1'b1;

        // Reset clears previously written registers asynchronously.
        drive(1'b1, T0, 32'hDEAD_BEEF, T0, T6);
        tick();
        drive(1'b1, T6, 32'h1234_5678, ZERO, ZERO);
        tick();
        drive(1'b0, ZERO, 32'h0, T0, T6);
        chk("pre_reset", 32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678);
        #2;
        rst_n = 1'b0;
        chk("reset_async", 32'h0, 32'h0, 32'h0, 32'h0);
        rst_n = 1'b1;
        sweep("reset_sweep", 1'b1);

        // Fill x1..x31 and read back in both directions.
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), sweep_val(i), ZERO, ZERO);
            tick();
        end
        sweep("rw_sweep", 1'b0);

        // Writes to x0 are dropped and never forwarded.
        drive(1'b1, ZERO, 32'hFFFF_FFFF, ZERO, RA);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("x0_write", 32'h0, 32'h0000_1001, 32'h0, 32'h0000_1001);
        end
        sweep("x0_sweep", 1'b0);

        // Same-cycle forwarding to both ports vs. stored contents.
        drive(1'b1, T2, 32'hAAAA_0000, ZERO, ZERO);
        tick();
        drive(1'b1, T2, 32'h5555_FFFF, T2, T2);
        #1;
        chk("bypass_pre", 32'h5555_FFFF, 32'h5555_FFFF, 32'hAAAA_0000, 32'hAAAA_0000);
        tick();
        drive(1'b0, ZERO, 32'h0, T2, T2);
        chk("bypass_post", 32'h5555_FFFF, 32'h5555_FFFF, 32'h5555_FFFF, 32'h5555_FFFF);
        drive(1'b1, S0, 32'h0BAD_0008, T2, S0);
        #1;
        chk("bypass_port1", 32'h5555_FFFF, 32'h0BAD_0008, 32'h5555_FFFF, 32'h0000_1008);
        drive(1'b0, S0, 32'h0BAD_0008, T2, S0);
        tick();
        chk("bypass_withdrawn", 32'h5555_FFFF, 32'h0000_1008, 32'h5555_FFFF, 32'h0000_1008);

        // Write enable low: no write, no forwarding.
        rst_n = 1'b0;
        drive(1'b0, ZERO, 32'h0, T2, S0);
        #1;
        chk("reset2", 32'h0, 32'h0, 32'h0, 32'h0);
        rst_n = 1'b1;
        drive(1'b0, S1, 32'hCAFE_0001, S1, S1);
        #1;
        chk("ena_gate_pre", 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        chk("ena_gate_post", 32'h0, 32'h0, 32'h0, 32'h0);

        // Reset asserted half a cycle before a pending write.
        tick();
        drive(1'b1, TP, 32'h0000_0077, TP, ZERO);
        #1;
        chk("midwr_bypass", 32'h0000_0077, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midwr_reset", 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        chk("midwr_after_edge", 32'h0, 32'h0, 32'h0, 32'h0);
        drive(1'b0, ZERO, 32'h0, TP, TP);
        rst_n = 1'b1;
        tick();
        chk("midwr_after_deassert", 32'h0, 32'h0, 32'h0, 32'h0);

        // First write after reset release lands on the next edge.
        drive(1'b1, TP, 32'h0000_0055, ZERO, ZERO);
        tick();
        drive(1'b0, ZERO, 32'h0, TP, TP);
        chk("post_reset_write", 32'h0000_0055, 32'h0000_0055, 32'h0000_0055, 32'h0000_0055);

        #5;
        checks++;
        if (name_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", name_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
